mod6_sequence_monitor: RTL

- Downstream consumer of the 3-bit MOD-6 counter output.
- Samples count_in on the rising clk edge. The upstream counter changes on the falling edge, so the value is stable when sampled.
- Checks the sequence 0,1,2,3,4,5,0,…, counts completed wraps, and raises a one-cycle wrap pulse for the next stage.
- Detects illegal, skipped and stuck counts, holds them as sticky faults, and leaves fault only through clr_err.

---
 rtl/mod6_mon_pkg.sv | 18 +
 rtl/mod6_mon_sat_ctr.sv | 21 ++
 rtl/mod6_sequence_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mod6_mon_pkg.sv
// Shared types and constants for the MOD-6 sequence monitor.
package mod6_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_SKIP    = 2'd2;
   localparam logic [1:0] ERR_STUCK   = 2'd3;

   localparam int unsigned DEF_MOD = 6;
   localparam int unsigned DEF_CW  = 3;

endpackage

// File: rtl/mod6_mon_sat_ctr.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module mod6_mon_sat_ctr #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear has priority over increment; increment stops at all-ones.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mod6_sequence_monitor.sv
// Checks the 0..MOD-1 wrap sequence from an upstream counter, counts wraps,
// and latches illegal / skipped / stuck faults until clr_err.
module mod6_sequence_monitor
   import mod6_mon_pkg::*;
#(
   parameter int unsigned MOD         = DEF_MOD,
   parameter int unsigned CW          = DEF_CW,
   parameter int unsigned STUCK_LIMIT = 4,
   parameter int unsigned WC_W        = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [CW-1:0]   count_in,
   input  logic            clr_err,
   output logic            locked,
   output logic            wrap_pulse,
   output logic [WC_W-1:0] wrap_count,
   output logic            err_illegal,
   output logic            err_skip,
   output logic            err_stuck,
   output logic [1:0]      err_code
);

   localparam int unsigned     SW        = (STUCK_LIMIT > 2) ? $clog2(STUCK_LIMIT) : 1;
   localparam logic [CW:0]     MOD_W     = (CW+1)'(MOD);
   localparam logic [CW-1:0]   LAST      = CW'(MOD - 1);
   localparam logic [SW-1:0]   STUCK_TOP = SW'(STUCK_LIMIT - 1);

   state_t          state;
   logic [CW-1:0]   prev;
   logic [CW-1:0]   exp_val;
   logic [SW-1:0]   stuck_cnt;
   logic            is_illegal;
   logic            is_repeat;
   logic            is_next;
   logic            is_zero;
   logic            stuck_last;
   logic            sample_track;
   logic            stuck_inc;
   logic            stuck_clr;
   logic            do_wrap;

   // Decode the current sample against the tracked value, in check priority order.
   always_comb begin
      exp_val      = (prev == LAST) ? '0 : prev + 1'b1;
      is_illegal   = {1'b0, count_in} >= MOD_W;
      is_repeat    = (count_in == prev);
      is_next      = (count_in == exp_val);
      is_zero      = (count_in == '0);
      stuck_last   = ((stuck_cnt + 1'b1) == STUCK_TOP);
      sample_track = en && (state == TRACK);
      stuck_inc    = sample_track && !is_illegal && is_repeat;
      do_wrap      = sample_track && !is_illegal && !is_repeat && is_next && (prev == LAST);
      stuck_clr    = (sample_track && !is_illegal && !is_repeat && (is_next || is_zero))
                   || (en && (state == FAULT) && clr_err)
                   || (en && (state == IDLE));
   end

   mod6_mon_sat_ctr #(.W(SW)) u_stuck_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (stuck_clr),
      .inc   (stuck_inc),
      .count (stuck_cnt)
   );

   mod6_mon_sat_ctr #(.W(WC_W)) u_wrap_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (do_wrap),
      .count (wrap_count)
   );

   // Monitor FSM with registered status outputs; en low freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         prev        <= '0;
         locked      <= 1'b0;
         wrap_pulse  <= 1'b0;
         err_illegal <= 1'b0;
         err_skip    <= 1'b0;
         err_stuck   <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         wrap_pulse <= 1'b0;
         if (en) begin
            case (state)
               IDLE: begin
                  if (is_illegal) begin
                     state       <= FAULT;
                     err_illegal <= 1'b1;
                     err_code    <= ERR_ILLEGAL;
                  end else if (is_zero) begin
                     state  <= TRACK;
                     prev   <= '0;
                     locked <= 1'b1;
                  end
               end
               TRACK: begin
                  if (is_illegal) begin
                     state       <= FAULT;
                     locked      <= 1'b0;
                     err_illegal <= 1'b1;
                     err_code    <= ERR_ILLEGAL;
                  end else if (is_repeat) begin
                     if (stuck_last) begin
                        state     <= FAULT;
                        locked    <= 1'b0;
                        err_stuck <= 1'b1;
                        err_code  <= ERR_STUCK;
                     end
                  end else if (is_next) begin
                     prev       <= count_in;
                     wrap_pulse <= (prev == LAST);
                  end else if (is_zero) begin
                     prev <= '0;
                  end else begin
                     state    <= FAULT;
                     locked   <= 1'b0;
                     err_skip <= 1'b1;
                     err_code <= ERR_SKIP;
                  end
               end
               FAULT: begin
                  if (clr_err) begin
                     state       <= IDLE;
                     err_illegal <= 1'b0;
                     err_skip    <= 1'b0;
                     err_stuck   <= 1'b0;
                     err_code    <= ERR_NONE;
                  end
               end
               default: begin
                  state  <= IDLE;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
